// File: rtl/serial_adder_if.sv
// Request/response bundle for the bit-serial adder: the master supplies
// operands and start; the slave reports busy, done and the registered result.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: a single full-adder cell consumes one operand bit per
// cycle, LSB first, and the result is published for one cycle in DONE.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;
  logic             accept;

  // The one full-adder cell plus the result shift-in of its sum bit.
  always_comb begin
    fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_cout  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    res_d    = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    last_bit = (cnt_q == CW'(WIDTH - 1));
    accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= RUN;
        a_q     <= bus.a;
        b_q     <= bus.b;
        carry_q <= bus.cin;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= res_d;
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CW'(1);
            if (last_bit) begin
              // carry_q is the carry into the MSB at this step.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sum_q   <= res_d;
              cout_q  <= fa_cout;
              ovf_q   <= carry_q ^ fa_cout;
            end
          end
          DONE: state_q <= IDLE;
          IDLE: ;
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked
// against plain-arithmetic expectations queued at each accepted start.
module tb_serial_adder;
  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8;
  exp_t e1;
  int   busy_run8;
  int   busy_run1;
  logic [9:0] hold8;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ordinary integer addition, signed overflow from operand/result signs.
  function automatic exp_t model(input int unsigned w, input logic [63:0] a,
                                 input logic [63:0] b, input logic cin, input int c);
    exp_t        r;
    logic [64:0] full;
    logic [63:0] mask;
    full   = {1'b0, a} + {1'b0, b} + 65'(cin);
    mask   = (w == 64) ? '1 : ((64'(1) << w) - 64'(1));
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
    r.cyc  = c;
    return r;
  endfunction

  // Called just after an edge; returns just after the edge that enters DONE.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input bit mid_pulse, input bit hold);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model(8, 64'(a), 64'(b), cin, cyc));
    bus8.start = hold;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (mid_pulse) bus8.start = (k == 2);
    end
  endtask

  task automatic issue1(input logic a, input logic b, input logic cin);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.start = 1'b1;
    @(posedge clk); #1;
    q1.push_back(model(1, 64'(a), 64'(b), cin, cyc));
    bus1.start = 1'b0;
    bus1.a = ~a; bus1.b = ~b; bus1.cin = ~cin;
    @(posedge clk); #1;
  endtask

  // Monitor for the 8-bit instance: results, latency, busy length, hold.
  always @(negedge clk) begin
    if (rst) begin
      busy_run8 = 0;
      hold8 = '0;
    end else begin
      if (bus8.busy) busy_run8++;
      if (bus8.done) begin
        check("busy_with_done8", 64'(bus8.busy), 64'(0));
        if (q8.size() == 0) begin
          check("spurious_done8", 64'(1), 64'(0));
        end else begin
          e8 = q8.pop_front();
          check("sum8", 64'(bus8.sum), e8.sum);
          check("cout8", 64'(bus8.cout), 64'(e8.cout));
          check("ovf8", 64'(bus8.ovf), 64'(e8.ovf));
          check("latency8", 64'(cyc - e8.cyc), 64'(8));
          check("busy_len8", 64'(busy_run8), 64'(8));
          hold8 = {e8.cout, e8.ovf, e8.sum[7:0]};
        end
        busy_run8 = 0;
      end else begin
        check("hold8", 64'({bus8.cout, bus8.ovf, bus8.sum}), 64'(hold8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy_run1 = 0;
    end else begin
      if (bus1.busy) busy_run1++;
      if (bus1.done) begin
        check("busy_with_done1", 64'(bus1.busy), 64'(0));
        if (q1.size() == 0) begin
          check("spurious_done1", 64'(1), 64'(0));
        end else begin
          e1 = q1.pop_front();
          check("sum1", 64'(bus1.sum), e1.sum);
          check("cout1", 64'(bus1.cout), 64'(e1.cout));
          check("ovf1", 64'(bus1.ovf), 64'(e1.ovf));
          check("latency1", 64'(cyc - e1.cyc), 64'(1));
          check("busy_len1", 64'(busy_run1), 64'(1));
        end
        busy_run1 = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus8.busy), 64'(0));
    check("rst_done", 64'(bus8.done), 64'(0));
    check("rst_sum", 64'(bus8.sum), 64'(0));
    check("rst_cout", 64'(bus8.cout), 64'(0));
    check("rst_ovf", 64'(bus8.ovf), 64'(0));
    check("rst_busy1", 64'(bus1.busy), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases, back-to-back through DONE.
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    issue8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    issue8(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    issue8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Start pulsed mid-run with operands changing underneath.
    issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
    @(posedge clk); #1;

    // Start held high: new operands presented on each DONE cycle.
    for (int i = 0; i < 5; i++)
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b1);
    bus8.start = 1'b0;
    @(posedge clk); #1;

    // Abort at RUN cycle 4, then start on the first edge after reset.
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(bus8.busy), 64'(0));
    check("abort_done", 64'(bus8.done), 64'(0));
    check("abort_sum", 64'(bus8.sum), 64'(0));
    check("abort_cout", 64'(bus8.cout), 64'(0));
    check("abort_ovf", 64'(bus8.ovf), 64'(0));
    rst = 1'b0;
    issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);

    // Random traffic with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // WIDTH=1: every operand/carry combination.
    for (int v = 7; v >= 0; v--)
      issue1(1'(v >> 2), 1'(v >> 1), 1'(v));

    for (int i = 0; i < 50 && (q8.size() != 0 || q1.size() != 0); i++)
      @(posedge clk);
    @(negedge clk);
    check("drain_q8", 64'(q8.size()), 64'(0));
    check("drain_q1", 64'(q1.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
